// File: rtl/regfile_sb.sv
// ============================================================================
//  Module      : regfile_sb
//  Description : Multi-read-port register file with write bypass, optional
//                hardwired x0 and a per-register pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   Rnum,
  output logic [NRD*XLEN-1:0] Rd,
  output logic [NRD-1:0]      Rrdy,
  input  logic                Wen,
  input  logic [AW-1:0]       Wnum,
  input  logic [XLEN-1:0]     Wd,
  input  logic                Iss_en,
  input  logic [AW-1:0]       Iss_num,
  input  logic                Flush,
  output logic [NREG-1:0]     Busy,
  output logic [AW:0]         Nbusy
);

  localparam logic [AW:0] c_nreg = (AW+1)'(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_nbusy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_wr_ok;
  logic            w_iss_ok;
  logic            w_inc;
  logic            w_dec;

  assign w_wr_ok  = Wen && ({1'b0, Wnum} < c_nreg) &&
                    !((ZERO_REG != 0) && (Wnum == '0));
  assign w_iss_ok = Iss_en && ({1'b0, Iss_num} < c_nreg) &&
                    !((ZERO_REG != 0) && (Iss_num == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
    end else if (w_wr_ok) begin
      r_mem[Wnum] <= Wd;
    end
  end

  // A new issue supersedes a same-cycle writeback to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREG; r++) begin
      if (w_iss_ok && (Iss_num == AW'(r)))
        w_busy_nxt[r] = 1'b1;
      else if (Wen && (Wnum == AW'(r)))
        w_busy_nxt[r] = 1'b0;
    end
    if (Flush) w_busy_nxt = '0;
  end

  // Outside a flush at most one bit can rise and at most one can fall.
  assign w_inc = |(w_busy_nxt & ~r_busy);
  assign w_dec = |(r_busy & ~w_busy_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_nbusy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (Flush)
        r_nbusy <= '0;
      else
        r_nbusy <= r_nbusy + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  assign Busy  = r_busy;
  assign Nbusy = r_nbusy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_rdy;
    logic            w_zero;
    logic            w_valid;

    assign w_addr  = Rnum[k*AW +: AW];
    assign w_zero  = (ZERO_REG != 0) && (w_addr == '0);
    assign w_valid = ({1'b0, w_addr} < c_nreg);

    always_comb begin
      w_data = '0;
      w_rdy  = 1'b1;
      if (w_valid && !w_zero) begin
        if ((BYPASS != 0) && w_wr_ok && (Wnum == w_addr)) begin
          w_data = Wd;
        end else begin
          w_data = r_mem[w_addr];
          w_rdy  = ~r_busy[w_addr];
        end
      end
    end

    assign Rd[k*XLEN +: XLEN] = w_data;
    assign Rrdy[k]            = w_rdy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed, table-driven bench for regfile_sb.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance (bypass on) and its twin with bypass off share inputs
  logic [9:0]  rnum;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rrdy, rrdy_nb;
  logic        wen, iss, flush;
  logic [4:0]  wnum, inum;
  logic [31:0] wd;
  logic [31:0] busy, busy_nb;
  logic [5:0]  nbusy, nbusy_nb;

  // three-port, 16-register, 64-bit instance
  logic [11:0]  rnum3;
  logic [191:0] rd3;
  logic [2:0]   rrdy3;
  logic         wen3, iss3, flush3;
  logic [3:0]   wnum3, inum3;
  logic [63:0]  wd3;
  logic [15:0]  busy3;
  logic [4:0]   nbusy3;

  regfile_sb dut (
    .clk(clk), .rst(rst), .Rnum(rnum), .Rd(rd), .Rrdy(rrdy),
    .Wen(wen), .Wnum(wnum), .Wd(wd), .Iss_en(iss), .Iss_num(inum),
    .Flush(flush), .Busy(busy), .Nbusy(nbusy)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .Rnum(rnum), .Rd(rd_nb), .Rrdy(rrdy_nb),
    .Wen(wen), .Wnum(wnum), .Wd(wd), .Iss_en(iss), .Iss_num(inum),
    .Flush(flush), .Busy(busy_nb), .Nbusy(nbusy_nb)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut3 (
    .clk(clk), .rst(rst), .Rnum(rnum3), .Rd(rd3), .Rrdy(rrdy3),
    .Wen(wen3), .Wnum(wnum3), .Wd(wd3), .Iss_en(iss3), .Iss_num(inum3),
    .Flush(flush3), .Busy(busy3), .Nbusy(nbusy3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  inum;
    logic        flush;
    logic [4:0]  ra, rb;
    logic [31:0] e0, e1;
    logic [1:0]  erdy;
    logic [31:0] ebusy;
    logic [5:0]  enb;
  } vec_t;

  function automatic vec_t mkv(int w, int wn, logic [31:0] d, int is, int in, int fl,
                               int a, int b, logic [31:0] x0, logic [31:0] x1,
                               int ry, logic [31:0] eb, int nb);
    vec_t v;
    v.wen = 1'(w);  v.wnum = 5'(wn); v.wd = d;
    v.iss = 1'(is); v.inum = 5'(in); v.flush = 1'(fl);
    v.ra = 5'(a);   v.rb = 5'(b);    v.e0 = x0; v.e1 = x1;
    v.erdy = 2'(ry); v.ebusy = eb;   v.enb = 6'(nb);
    return v;
  endfunction

  function automatic logic [63:0] f3(int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0001;
  endfunction

  vec_t tv[19];

  initial begin
    //                  wen wn wd            is in fl ra rb e0       e1       rdy    busy        nb
    tv[0]  = mkv(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,  32'h0,  2'b11, 32'h0,      0);
    tv[1]  = mkv(0, 0, 32'h0,        1, 0, 0, 0, 7, 32'h0,  32'h7,  2'b11, 32'h0,      0);
    tv[2]  = mkv(0, 0, 32'h0,        1, 3, 0, 3, 3, 32'h3,  32'h3,  2'b11, 32'h8,      1);
    tv[3]  = mkv(0, 0, 32'h0,        0, 0, 0, 3, 1, 32'h3,  32'h1,  2'b10, 32'h8,      1);
    tv[4]  = mkv(1, 3, 32'h33,       1, 3, 0, 3, 2, 32'h33, 32'h2,  2'b11, 32'h8,      1);
    tv[5]  = mkv(1, 3, 32'h44,       0, 0, 0, 4, 3, 32'h4,  32'h44, 2'b11, 32'h0,      0);
    tv[6]  = mkv(0, 0, 32'h0,        0, 0, 0, 3, 0, 32'h44, 32'h0,  2'b11, 32'h0,      0);
    tv[7]  = mkv(0, 0, 32'h0,        1, 1, 0, 1, 2, 32'h1,  32'h2,  2'b11, 32'h2,      1);
    tv[8]  = mkv(0, 0, 32'h0,        1, 2, 0, 1, 2, 32'h1,  32'h2,  2'b10, 32'h6,      2);
    tv[9]  = mkv(0, 0, 32'h0,        1, 4, 0, 2, 4, 32'h2,  32'h4,  2'b10, 32'h16,     3);
    tv[10] = mkv(0, 0, 32'h0,        1, 6, 1, 4, 1, 32'h4,  32'h1,  2'b00, 32'h0,      0);
    tv[11] = mkv(0, 0, 32'h0,        0, 0, 0, 6, 4, 32'h6,  32'h4,  2'b11, 32'h0,      0);
    tv[12] = mkv(0, 0, 32'h0,        0, 0, 0, 1, 2, 32'h1,  32'h2,  2'b11, 32'h0,      0);
    tv[13] = mkv(0, 0, 32'h0,        1, 7, 0, 7, 5, 32'h7,  32'h5,  2'b11, 32'h80,     1);
    tv[14] = mkv(1, 7, 32'h77,       0, 0, 1, 7, 5, 32'h77, 32'h5,  2'b11, 32'h0,      0);
    tv[15] = mkv(0, 0, 32'h0,        0, 0, 0, 7, 6, 32'h77, 32'h6,  2'b11, 32'h0,      0);
    tv[16] = mkv(0, 0, 32'h0,        1, 8, 0, 8, 9, 32'h8,  32'h9,  2'b11, 32'h100,    1);
    tv[17] = mkv(0, 0, 32'h0,        1, 8, 0, 8, 9, 32'h8,  32'h9,  2'b10, 32'h100,    1);
    tv[18] = mkv(1, 8, 32'h88,       0, 0, 0, 9, 8, 32'h9,  32'h88, 2'b11, 32'h0,      0);

    rst = 1'b1;
    rnum = {5'd7, 5'd3}; wen = 0; wnum = 0; wd = 0; iss = 0; inum = 0; flush = 0;
    rnum3 = {4'd5, 4'd2, 4'd1}; wen3 = 0; wnum3 = 0; wd3 = 0; iss3 = 0; inum3 = 0; flush3 = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rd", rd, 64'h0);
    chk("rst_rrdy", rrdy, 2'b11);
    chk("rst_busy", busy, 32'h0);
    chk("rst_nbusy", nbusy, 6'h0);
    chk("rst_rd3", rd3, 192'h0);
    chk("rst_rrdy3", rrdy3, 3'b111);
    chk("rst_nbusy3", nbusy3, 5'h0);
    rst = 1'b0;

    // fill r1..r31 and sweep every read pair
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wen = 1'b1; wnum = 5'(i); wd = 32'(i);
    end
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        rnum = {5'(j), 5'(i)};
        #1;
        chk("sweep_rd", rd, {32'(j), 32'(i)});
        chk("sweep_rrdy", rrdy, 2'b11);
      end
    end

    // scoreboard / x0 / bypass vectors
    for (int v = 0; v < 19; v++) begin
      @(negedge clk);
      wen = tv[v].wen; wnum = tv[v].wnum; wd = tv[v].wd;
      iss = tv[v].iss; inum = tv[v].inum; flush = tv[v].flush;
      rnum = {tv[v].rb, tv[v].ra};
      #1;
      chk($sformatf("v%0d_rd0", v), rd[31:0], tv[v].e0);
      chk($sformatf("v%0d_rd1", v), rd[63:32], tv[v].e1);
      chk($sformatf("v%0d_rrdy", v), rrdy, tv[v].erdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", v), busy, tv[v].ebusy);
      chk($sformatf("v%0d_nbusy", v), nbusy, tv[v].enb);
    end
    @(negedge clk);
    wen = 0; iss = 0; flush = 0;

    // bypass on versus off
    @(negedge clk);
    wen = 1'b1; wnum = 5'd5; wd = 32'hA5A5A5A5; rnum = {5'd0, 5'd5};
    #1;
    chk("byp_pre", rd[31:0], 32'hA5A5A5A5);
    chk("nobyp_pre", rd_nb[31:0], 32'h5);
    @(posedge clk); #1;
    chk("nobyp_post", rd_nb[31:0], 32'hA5A5A5A5);
    @(negedge clk);
    wen = 1'b0;

    // asynchronous reset between edges
    @(negedge clk);
    iss = 1'b1; inum = 5'd9;
    @(negedge clk);
    iss = 1'b0; rnum = {5'd9, 5'd1};
    #1;
    chk("pre_arst_busy", busy, 32'h200);
    #1 rst = 1'b1;
    #1;
    chk("arst_rd", rd, 64'h0);
    chk("arst_rrdy", rrdy, 2'b11);
    chk("arst_busy", busy, 32'h0);
    chk("arst_nbusy", nbusy, 6'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    wen = 1'b1; wnum = 5'd2; wd = 32'h1234; rnum = {5'd2, 5'd1};
    @(negedge clk);
    wen = 1'b0;
    #1;
    chk("post_arst_rd", rd, {32'h1234, 32'h0});

    // three-port wide instance
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      wen3 = 1'b1; wnum3 = 4'(i); wd3 = f3(i);
    end
    @(negedge clk);
    wen3 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      iss3 = 1'b1; inum3 = 4'(i);
      @(negedge clk);
    end
    iss3 = 1'b0;
    rnum3 = {4'd15, 4'd9, 4'd3};
    #1;
    chk("w3_nbusy_full", nbusy3, 5'd15);
    chk("w3_busy_full", busy3, 16'hFFFE);
    chk("w3_rd", rd3, {f3(15), f3(9), f3(3)});
    chk("w3_rrdy", rrdy3, 3'b000);
    rnum3 = {4'd0, 4'd3, 4'd0};
    #1;
    chk("w3_rd_x0", rd3, {64'h0, f3(3), 64'h0});
    chk("w3_rrdy_x0", rrdy3, 3'b101);
    @(negedge clk);
    wen3 = 1'b1; wnum3 = 4'd9; wd3 = 64'hFFFF;
    @(posedge clk); #1;
    chk("w3_nbusy_dec", nbusy3, 5'd14);
    @(negedge clk);
    wen3 = 1'b0; flush3 = 1'b1;
    @(posedge clk); #1;
    chk("w3_flush_nbusy", nbusy3, 5'd0);
    chk("w3_flush_busy", busy3, 16'h0);
    chk("w3_flush_rrdy", rrdy3, 3'b111);
    chk("w3_flush_rd", rd3, {64'h0, f3(3), 64'h0});
    @(negedge clk);
    flush3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
